// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// FSM state encodings and the width of the reused adder slice.
package adder_seq_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple-carry adder slice, purely combinational.
module adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic c;

  always_comb begin
    s_o = '0;
    c   = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    c_o = c;
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// WIDTH-bit add/subtract built from one reused 4-bit slice, one nibble per cycle, LSB first.
// Result valid NIBBLES cycles after accept; held in DONE until out_ready, new operands refused meanwhile.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                     sub,
  input  logic                     c_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                     c_out,
  output logic                     ovf
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_e                            state_q;
  logic   [IDXW-1:0]                 idx_q;
  logic                              carry_q;
  logic   [NIBBLES-1:0][SLICE_W-1:0] a_q;
  logic   [NIBBLES-1:0][SLICE_W-1:0] b_q;
  logic   [NIBBLES-1:0][SLICE_W-1:0] sum_q;
  logic                              c_out_q;
  logic                              ovf_q;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_c;

  adder4 u_slice (
    .a_i (a_q[idx_q]),
    .b_i (b_q[idx_q]),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // Handshake outputs are pure state decodes, so no input reaches them combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1, so c_in is irrelevant when sub is set.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          sum_q[idx_q] <= slice_s;
          carry_q      <= slice_c;
          if (idx_q == LAST_IDX) begin
            c_out_q <= slice_c;
            ovf_q   <= (a_q[NIBBLES-1][SLICE_W-1] == b_q[NIBBLES-1][SLICE_W-1]) &&
                       (slice_s[SLICE_W-1] != a_q[NIBBLES-1][SLICE_W-1]);
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl with NIBBLES=4 (16-bit operands).
module tb_adder_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int   n_chk = 0;
  int   n_bad = 0;
  res_t sb_q[$];
  res_t held;

  adder_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference built from integer arithmetic rather than the slice/carry formulation.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic ci);
    res_t r;
    int sx, sy, sr;
    logic [W:0] u;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r.s  = x - y;
      r.co = (x >= y);
      sr   = sx - sy;
    end else begin
      u    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.s  = u[W-1:0];
      r.co = u[W];
      sr   = sx + sy + int'(ci);
    end
    r.ov = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  // Present operands, wait for accept; leaves the bench at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic ci);
    int n;
    @(negedge clk);
    a = x; b = y; sub = s; c_in = ci; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    sb_q.push_back(model(x, y, s, ci));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int   lat;
    res_t e;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(NIB));
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      held = e;
      chk({tag, "_sum"}, 32'(sum), 32'(e.s));
      chk({tag, "_cout"}, 32'(c_out), 32'(e.co));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic s, input logic ci);
    issue(x, y, s, ci);
    collect(tag);
    release_result(tag);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op("add_basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0);
    op("add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op("add_cin",     16'hFFFF, 16'h0000, 1'b0, 1'b1);
    op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0);
    op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    // Backpressure: result must hold while new operands are offered and refused.
    issue(16'h0A0B, 16'h0102, 1'b0, 1'b0);
    collect("bp");
    a = 16'h1111; b = 16'h2222; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'(held.s));
    end
    in_valid = 1'b0;
    release_result("bp");
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      chk("bp_dropped", 32'(out_valid), 32'd0);
    end

    // Reset mid-operation with idx=2.
    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
